uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_param_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_param.sv | 138 +++++++++++++
 tb/tb_uart_tx_param.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

   // Wide enough to index nine data bits.
   localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_tx_param_if.sv
// Word-level valid/ready handshake into the UART transmitter.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] din;
   logic                 valid;
   logic                 ready;

   modport master (output din, output valid, input ready);
   modport slave  (input din, input valid, output ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Held at zero while disabled so every frame starts on a fresh period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits; registered tx output.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_param_if.slave     s,
   output logic               tx,
   output logic               busy,
   output logic               done
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
   end
   if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
      $error("uart_tx_param: PARITY_EN must be 0 or 1");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx_param: PARITY_ODD must be 0 or 1");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
   localparam bit PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input bit mode);
      return (^d) ^ (mode == PAR_ODD);
   endfunction

   uart_state_t          state, state_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic                 par, par_n;
   logic                 tx_n, done_n;
   logic                 tick;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk (clk),
      .rst (rst),
      .en  (state != IDLE),
      .tick(tick)
   );

   assign s.ready = (state == IDLE);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         par     <= par_n;
         tx      <= tx_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      par_n     = par;
      done_n    = 1'b0;
      tx_n      = 1'b1;

      case (state)
         IDLE: begin
            if (s.valid) begin
               state_n   = START;
               shreg_n   = s.din;
               bit_cnt_n = '0;
               par_n     = parity_of(s.din, PAR_MODE);
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_n = shreg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) state_n = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // tx is registered from the next state so the line changes on the same
      // edge as the state, e.g. going low right at the handshake edge.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         PARITY:  tx_n = par;
         default: tx_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four parameterisations checked cycle by cycle
// against a frame model built from the serial framing rules.
module tb_uart_tx_param;

   localparam int NI = 4;
   localparam int DB  [NI] = '{8, 8, 8, 5};
   localparam int CPB [NI] = '{16, 16, 16, 4};
   localparam int PE  [NI] = '{0, 1, 1, 0};
   localparam int PO  [NI] = '{0, 0, 1, 0};
   localparam int SB  [NI] = '{1, 1, 1, 2};

   logic          clk = 1'b0;
   logic          rst;
   logic [8:0]    din_d [NI];
   logic [NI-1:0] valid_d;
   logic [NI-1:0] tx_w, busy_w, done_w, ready_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8)) if0 ();
   uart_tx_param_if #(.DATA_BITS(8)) if1 ();
   uart_tx_param_if #(.DATA_BITS(8)) if2 ();
   uart_tx_param_if #(.DATA_BITS(5)) if3 ();

   assign if0.din = din_d[0][7:0];
   assign if1.din = din_d[1][7:0];
   assign if2.din = din_d[2][7:0];
   assign if3.din = din_d[3][4:0];
   assign if0.valid = valid_d[0];
   assign if1.valid = valid_d[1];
   assign if2.valid = valid_d[2];
   assign if3.valid = valid_d[3];
   assign ready_w[0] = if0.ready;
   assign ready_w[1] = if1.ready;
   assign ready_w[2] = if2.ready;
   assign ready_w[3] = if3.ready;

   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      dut0 (.clk(clk), .rst(rst), .s(if0.slave), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      dut1 (.clk(clk), .rst(rst), .s(if1.slave), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
      dut2 (.clk(clk), .rst(rst), .s(if2.slave), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
   uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      dut3 (.clk(clk), .rst(rst), .s(if3.slave), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

   function automatic int frame_len(input int k);
      return (1 + DB[k] + PE[k] + SB[k]) * CPB[k];
   endfunction

   // Expected line level n cycles after the first start-bit cycle.
   function automatic logic exp_tx(input int k, input logic [8:0] d, input int n);
      int   b;
      logic p;
      b = n / CPB[k];
      if (b == 0) return 1'b0;
      if (b <= DB[k]) return d[b-1];
      if (PE[k] != 0 && b == DB[k] + 1) begin
         p = 1'b0;
         for (int i = 0; i < DB[k]; i++) p = p ^ d[i];
         return p ^ (PO[k] != 0);
      end
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int k, input string tag);
      chk($sformatf("%s tx%0d", tag, k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("%s busy%0d", tag, k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("%s ready%0d", tag, k), 32'(ready_w[k]), 32'd1);
      chk($sformatf("%s done%0d", tag, k), 32'(done_w[k]), 32'd0);
   endtask

   // Present a word; after the accepting edge either drop valid (scrambling
   // din) or keep valid high with the next word queued.
   task automatic start(input int k, input logic [8:0] d, input bit keep, input logic [8:0] nd);
      @(negedge clk);
      din_d[k]   = d;
      valid_d[k] = 1'b1;
      @(posedge clk);
      #1;
      if (keep) begin
         din_d[k] = nd;
      end else begin
         valid_d[k] = 1'b0;
         din_d[k]   = 9'($urandom);
      end
   endtask

   // Check a whole frame plus its done cycle; cycle 0 is the first tx-low cycle.
   task automatic frame(input int k, input logic [8:0] d, input bit wiggle);
      int len;
      len = frame_len(k);
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         chk($sformatf("tx%0d c%0d", k, n), 32'(tx_w[k]), 32'(exp_tx(k, d, n)));
         chk($sformatf("busy%0d c%0d", k, n), 32'(busy_w[k]), 32'd1);
         chk($sformatf("ready%0d c%0d", k, n), 32'(ready_w[k]), 32'd0);
         chk($sformatf("done%0d c%0d", k, n), 32'(done_w[k]), 32'd0);
         if (wiggle && n >= 2 && n < len - 3) begin
            valid_d[k] = 1'($urandom);
            din_d[k]   = 9'($urandom);
         end
         if (wiggle && n == len - 3) valid_d[k] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("done%0d end", k), 32'(done_w[k]), 32'd1);
      chk($sformatf("tx%0d end", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("ready%0d end", k), 32'(ready_w[k]), 32'd1);
      chk($sformatf("busy%0d end", k), 32'(busy_w[k]), 32'd0);
   endtask

   task automatic idle_for(input int k, input int cycles);
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         chk_idle(k, $sformatf("idle c%0d", n));
      end
   endtask

   logic [8:0] w, w2;

   initial begin
      rst     = 1'b1;
      valid_d = '0;
      for (int k = 0; k < NI; k++) din_d[k] = '0;

      // Reset state, while held and after release.
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) chk_idle(k, "rst");
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk_idle(k, "post-rst");

      // Directed frames.
      start(0, 9'h0A5, 1'b0, 9'h0);
      frame(0, 9'h0A5, 1'b0);
      idle_for(0, 2);
      start(1, 9'h007, 1'b0, 9'h0);
      frame(1, 9'h007, 1'b0);
      idle_for(1, 2);
      start(2, 9'h007, 1'b0, 9'h0);
      frame(2, 9'h007, 1'b0);
      idle_for(2, 2);
      start(3, 9'h01F, 1'b0, 9'h0);
      frame(3, 9'h01F, 1'b0);
      idle_for(3, 2);

      // Back-to-back: valid held high across the done cycle.
      start(0, 9'h055, 1'b1, 9'h0AA);
      frame(0, 9'h055, 1'b0);
      @(posedge clk);
      #1;
      valid_d[0] = 1'b0;
      frame(0, 9'h0AA, 1'b0);
      idle_for(0, 3);

      // Reset pulsed during data bit 3.
      w = 9'($urandom) & 9'h0FF;
      start(0, w, 1'b0, 9'h0);
      for (int n = 0; n < 4 * CPB[0] + 5; n++) begin
         @(negedge clk);
         chk($sformatf("tx0 pre-rst c%0d", n), 32'(tx_w[0]), 32'(exp_tx(0, w, n)));
      end
      #2;
      rst = 1'b1;
      #1;
      chk_idle(0, "mid-rst");
      w2 = 9'($urandom) & 9'h0FF;
      din_d[0]   = w2;
      valid_d[0] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk_idle(0, $sformatf("rst-hold c%0d", n));
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      valid_d[0] = 1'b0;
      frame(0, w2, 1'b0);
      idle_for(0, 2);

      // Randomised words, some with din/valid disturbed mid-frame.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NI; k++) begin
            w = 9'($urandom) & 9'((1 << DB[k]) - 1);
            start(k, w, 1'b0, 9'h0);
            frame(k, w, r != 0);
            idle_for(k, 3);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
